// File: rtl/pspin_her_gen_buf.sv
// HER generator: turns DMA completion beats into handler execution requests through a 2-entry output FIFO.
// Optional statistics counters and stat_* ports are enabled by defining HER_GEN_STATS_EN.
module pspin_her_gen_buf #(
  parameter int C_MSGID_WIDTH  = 10,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH      = 20,
  parameter int TAG_WIDTH      = 32,
  parameter int NUM_CTX        = 4,
  parameter int META_WIDTH     = 640,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          gen_valid,
  output logic                          gen_ready,
  input  logic [AXI_ADDR_WIDTH-1:0]     gen_addr,
  input  logic [LEN_WIDTH-1:0]          gen_len,
  input  logic [TAG_WIDTH-1:0]          gen_tag,
  input  logic                          conf_valid,
  output logic                          conf_ack,
  input  logic [NUM_CTX*META_WIDTH-1:0] conf_meta,
  input  logic [NUM_CTX-1:0]            conf_ctx_enabled,
  output logic                          her_valid,
  input  logic                          her_ready,
  output logic [C_MSGID_WIDTH-1:0]      her_msgid,
  output logic                          her_is_eom,
  output logic [$clog2(NUM_CTX)-1:0]    her_ctx_id,
  output logic [AXI_ADDR_WIDTH-1:0]     her_addr,
  output logic [AXI_ADDR_WIDTH-1:0]     her_size,
  output logic [AXI_ADDR_WIDTH-1:0]     her_xfer_size,
  output logic [META_WIDTH-1:0]         her_meta
`ifdef HER_GEN_STATS_EN
  ,
  input  logic                          stat_clear,
  output logic [NUM_CTX*CNT_WIDTH-1:0]  stat_her_count,
  output logic [CNT_WIDTH-1:0]          stat_fallback_count
`endif
);

  localparam int CTX_ID_WIDTH = $clog2(NUM_CTX);
  localparam int TAG_USED     = CTX_ID_WIDTH + 1 + C_MSGID_WIDTH;

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} cfg_state_t;

  typedef struct packed {
    logic [C_MSGID_WIDTH-1:0]  msgid;
    logic                      is_eom;
    logic [CTX_ID_WIDTH-1:0]   ctx_id;
    logic [AXI_ADDR_WIDTH-1:0] addr;
    logic [AXI_ADDR_WIDTH-1:0] size;
    logic [META_WIDTH-1:0]     meta;
  } her_t;

  cfg_state_t                  state, state_next;
  logic [NUM_CTX*META_WIDTH-1:0] ctx_meta;
  logic [NUM_CTX-1:0]          ctx_enabled;
  her_t                        entry0, entry1, new_her;
  logic [1:0]                  count;
  logic                        push, pop, fallback;
  logic [CTX_ID_WIDTH-1:0]     tag_ctx, eff_ctx;
  logic [AXI_ADDR_WIDTH-1:0]   len_ext;

  if (LEN_WIDTH >= AXI_ADDR_WIDTH) begin : g_len_trunc
    assign len_ext = gen_len[AXI_ADDR_WIDTH-1:0];
    if (LEN_WIDTH > AXI_ADDR_WIDTH) begin : g_len_unused
      logic unused_len_hi;
      assign unused_len_hi = ^gen_len[LEN_WIDTH-1:AXI_ADDR_WIDTH];
    end
  end else begin : g_len_ext
    assign len_ext = {{(AXI_ADDR_WIDTH-LEN_WIDTH){1'b0}}, gen_len};
  end

  if (TAG_WIDTH > TAG_USED) begin : g_tag_unused
    logic unused_tag_hi;
    assign unused_tag_hi = ^gen_tag[TAG_WIDTH-1:TAG_USED];
  end

  // Disabled contexts fall back to context 0, which is always enabled while beats flow.
  assign tag_ctx  = gen_tag[CTX_ID_WIDTH-1:0];
  assign fallback = !ctx_enabled[tag_ctx];
  assign eff_ctx  = fallback ? '0 : tag_ctx;

  always_comb begin
    new_her        = '0;
    new_her.msgid  = gen_tag[CTX_ID_WIDTH+1 +: C_MSGID_WIDTH];
    new_her.is_eom = gen_tag[CTX_ID_WIDTH];
    new_her.ctx_id = eff_ctx;
    new_her.addr   = gen_addr;
    new_her.size   = len_ext;
    new_her.meta   = ctx_meta[META_WIDTH*int'(eff_ctx) +: META_WIDTH];
  end

  assign gen_ready = (state == IDLE) && !conf_valid && ctx_enabled[0] && (count < 2'd2);
  assign push      = gen_valid && gen_ready;
  assign her_valid = (count != 2'd0);
  assign pop       = her_valid && her_ready;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    conf_ack   = 1'b0;
    case (state)
      IDLE:    if (conf_valid) state_next = DRAIN;
      DRAIN:   if (count == 2'd0) state_next = APPLY;
      APPLY: begin
        conf_ack   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ctx_meta    <= '0;
      ctx_enabled <= '0;
    end else if (state == APPLY) begin
      ctx_meta    <= conf_meta;
      ctx_enabled <= conf_ctx_enabled;
    end
  end

  // Shift-register FIFO: the head always sits in entry0 so outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count  <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= new_her;
          else               entry1 <= new_her;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) entry0 <= new_her;
          else begin
            entry0 <= entry1;
            entry1 <= new_her;
          end
        end
        default: ;
      endcase
    end
  end

  assign her_msgid     = entry0.msgid;
  assign her_is_eom    = entry0.is_eom;
  assign her_ctx_id    = entry0.ctx_id;
  assign her_addr      = entry0.addr;
  assign her_size      = entry0.size;
  assign her_xfer_size = entry0.size;
  assign her_meta      = entry0.meta;

`ifdef HER_GEN_STATS_EN
  // A clear in the same cycle as a beat wins over the increment.
  always_ff @(posedge clk) begin
    if (!rstn || stat_clear) begin
      stat_her_count      <= '0;
      stat_fallback_count <= '0;
    end else if (push) begin
      stat_her_count[CNT_WIDTH*int'(eff_ctx) +: CNT_WIDTH] <=
        stat_her_count[CNT_WIDTH*int'(eff_ctx) +: CNT_WIDTH] + CNT_WIDTH'(1);
      if (fallback) stat_fallback_count <= stat_fallback_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
